// File: rtl/adder_accumulator_ctrl.sv
// Purpose: sequences A <= A + B through an external combinational ripple adder.
// Latency: Run edge sampled at edge E -> Acc/Done valid after edge E+SETTLE_CYCLES+1.
// Backpressure: none; Load_B/Clear_A/Run edges arriving outside IDLE are dropped, not queued.
module adder_accumulator_ctrl #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] Sw,
  input  logic             Load_B,
  input  logic             Clear_A,
  input  logic             Run,
  output logic [WIDTH-1:0] Add_A,
  output logic [WIDTH-1:0] Add_B,
  input  logic [WIDTH-1:0] Add_Sum,
  input  logic             Add_Cout,
  output logic [WIDTH-1:0] Acc,
  output logic             Carry,
  output logic             Ovf,
  output logic             Busy,
  output logic             Done
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] HOLD    = 2'd3;

  // Counter only needs to hold SETTLE_CYCLES-1; keep at least one bit.
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic             ovf_q;
  logic             done_q;

  logic load_b_q;
  logic clear_a_q;
  logic run_q;

  logic evt_load_b;
  logic evt_clear_a;
  logic evt_run;

  assign evt_load_b  = Load_B  & ~load_b_q;
  assign evt_clear_a = Clear_A & ~clear_a_q;
  assign evt_run     = Run     & ~run_q;

  assign Add_A = a_q;
  assign Add_B = b_q;
  assign Acc   = a_q;
  assign Carry = carry_q;
  assign Ovf   = ovf_q;
  assign Done  = done_q;
  assign Busy  = (state == SETTLE) || (state == CAPTURE);

  // Edge-detect history; reset to 1 so a level held through reset is not seen as a fresh press.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      load_b_q  <= 1'b1;
      clear_a_q <= 1'b1;
      run_q     <= 1'b1;
    end else begin
      load_b_q  <= Load_B;
      clear_a_q <= Clear_A;
      run_q     <= Run;
    end
  end

  // Control FSM and operand/result registers; A and B only change in IDLE or at CAPTURE.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (evt_clear_a) begin
            a_q     <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
          end
          // B loads at the same edge the run starts, so the add sees the new B.
          if (evt_load_b) begin
            b_q <= Sw;
          end
          if (evt_run && !evt_clear_a) begin
            state <= SETTLE;
            cnt   <= CNT_LOAD;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            state <= CAPTURE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        CAPTURE: begin
          a_q     <= Add_Sum;
          carry_q <= Add_Cout;
          ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (Add_Sum[WIDTH-1] != a_q[WIDTH-1]);
          done_q  <= 1'b1;
          state   <= Run ? HOLD : IDLE;
        end
        HOLD: begin
          // Wait for release so a long press still produces a single add.
          if (!Run) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_accumulator_ctrl.sv
// Bench for adder_accumulator_ctrl with a behavioural adder attached.
// Expected results are queued at Run and compared when Done pulses.
// Vector table plus directed sequences for reset, long Run, same-cycle events and mid-add reset.
module tb_adder_accumulator_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [15:0] Sw;
  logic        Load_B;
  logic        Clear_A;
  logic        Run;
  logic [15:0] Add_A;
  logic [15:0] Add_B;
  logic [15:0] Add_Sum;
  logic        Add_Cout;
  logic [15:0] Acc;
  logic        Carry;
  logic        Ovf;
  logic        Busy;
  logic        Done;

  adder_accumulator_ctrl #(.WIDTH(16), .SETTLE_CYCLES(2)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Sw(Sw), .Load_B(Load_B), .Clear_A(Clear_A), .Run(Run),
    .Add_A(Add_A), .Add_B(Add_B), .Add_Sum(Add_Sum), .Add_Cout(Add_Cout),
    .Acc(Acc), .Carry(Carry), .Ovf(Ovf), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  // External ripple adder stand-in, Cin tied 0.
  logic [16:0] add_full;
  assign add_full = {1'b0, Add_A} + {1'b0, Add_B};
  assign Add_Sum  = add_full[15:0];
  assign Add_Cout = add_full[16];

  typedef struct packed {
    logic [15:0] sum;
    logic        carry;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        carry;
    logic        ovf;
  } vec_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard: every Done pulse must match the oldest pending expectation.
  always @(negedge Clk) begin
    if (Reset_n === 1'b1 && Done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: Done=1 with no add pending, Acc=%h (t=%0t)", Acc, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_acc",   {16'h0, Acc},   {16'h0, e.sum});
        chk("done_carry", {31'h0, Carry}, {31'h0, e.carry});
        chk("done_ovf",   {31'h0, Ovf},   {31'h0, e.ovf});
      end
    end
  end

  // Drive one cycle of events, then observe until any queued add drains (bounded).
  task automatic drive(input logic ld, input logic cl, input logic rn, input logic [15:0] sw,
                       input logic push, input exp_t e, output int busy);
    @(negedge Clk);
    Sw = sw; Load_B = ld; Clear_A = cl; Run = rn;
    if (push) exp_q.push_back(e);
    busy = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      if (i == 0) begin
        Load_B = 1'b0; Clear_A = 1'b0; Run = 1'b0;
      end
      if (Busy === 1'b1) busy++;
      #1;
      if (exp_q.size() == 0 && i >= 3) break;
    end
    if (push) chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  vec_t vecs[8];
  int   busy;
  int   d0;
  exp_t none;

  initial begin
    vecs[0] = '{a:16'h1234, b:16'h0001, sum:16'h1235, carry:1'b0, ovf:1'b0};
    vecs[1] = '{a:16'hFFFF, b:16'h0001, sum:16'h0000, carry:1'b1, ovf:1'b0};
    vecs[2] = '{a:16'h7FFF, b:16'h0001, sum:16'h8000, carry:1'b0, ovf:1'b1};
    vecs[3] = '{a:16'h8000, b:16'h8000, sum:16'h0000, carry:1'b1, ovf:1'b1};
    vecs[4] = '{a:16'h0F0F, b:16'hF0F0, sum:16'hFFFF, carry:1'b0, ovf:1'b0};
    vecs[5] = '{a:16'hFFFF, b:16'hFFFF, sum:16'hFFFE, carry:1'b1, ovf:1'b0};
    vecs[6] = '{a:16'h4000, b:16'h4000, sum:16'h8000, carry:1'b0, ovf:1'b1};
    vecs[7] = '{a:16'h8001, b:16'hFFFF, sum:16'h8000, carry:1'b1, ovf:1'b0};
    none = '0;

    // Reset with Run/Load_B held high: no load, no add after release.
    Reset_n = 1'b0; Sw = 16'hABCD; Load_B = 1'b1; Clear_A = 1'b0; Run = 1'b1;
    repeat (3) @(negedge Clk);
    chk("rst_acc",   {16'h0, Acc},   32'h0);
    chk("rst_b",     {16'h0, Add_B}, 32'h0);
    chk("rst_carry", {31'h0, Carry}, 32'h0);
    chk("rst_ovf",   {31'h0, Ovf},   32'h0);
    chk("rst_done",  {31'h0, Done},  32'h0);
    chk("rst_busy",  {31'h0, Busy},  32'h0);
    Reset_n = 1'b1;
    repeat (6) @(negedge Clk);
    chk("held_acc",  {16'h0, Acc},   32'h0);
    chk("held_b",    {16'h0, Add_B}, 32'h0);
    chk("held_busy", {31'h0, Busy},  32'h0);
    chk("held_done_cnt", done_cnt, 0);
    Load_B = 1'b0; Run = 1'b0;
    repeat (2) @(negedge Clk);

    // Basic: clear, load 0x1234, run; Busy for 3 cycles, one Done.
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, none, busy);
    drive(1'b1, 1'b0, 1'b0, 16'h1234, 1'b0, none, busy);
    chk("load_b", {16'h0, Add_B}, 32'h1234);
    d0 = done_cnt;
    drive(1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, '{sum:16'h1234, carry:1'b0, ovf:1'b0}, busy);
    chk("busy_cycles", busy, 3);
    chk("done_pulses", done_cnt - d0, 1);

    // Vector table: preset A via clear + load/run, then the add under test.
    foreach (vecs[k]) begin
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, none, busy);
      chk("clr_acc",   {16'h0, Acc},   32'h0);
      chk("clr_carry", {31'h0, Carry}, 32'h0);
      chk("clr_ovf",   {31'h0, Ovf},   32'h0);
      drive(1'b1, 1'b0, 1'b1, vecs[k].a, 1'b1, '{sum:vecs[k].a, carry:1'b0, ovf:1'b0}, busy);
      drive(1'b1, 1'b0, 1'b1, vecs[k].b, 1'b1,
            '{sum:vecs[k].sum, carry:vecs[k].carry, ovf:vecs[k].ovf}, busy);
    end

    // Run held 20 cycles with Load_B/Clear_A pulses during SETTLE: one add, operands untouched.
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, none, busy);
    drive(1'b1, 1'b0, 1'b1, 16'h0100, 1'b1, '{sum:16'h0100, carry:1'b0, ovf:1'b0}, busy);
    drive(1'b1, 1'b0, 1'b0, 16'h0011, 1'b0, none, busy);
    d0 = done_cnt;
    @(negedge Clk);
    Run = 1'b1;
    exp_q.push_back('{sum:16'h0111, carry:1'b0, ovf:1'b0});
    @(negedge Clk);
    Load_B = 1'b1; Clear_A = 1'b1; Sw = 16'h5555;
    @(negedge Clk);
    Load_B = 1'b0; Clear_A = 1'b0;
    repeat (18) @(negedge Clk);
    Run = 1'b0;
    repeat (5) @(negedge Clk);
    chk("hold_queue", exp_q.size(), 0);
    chk("hold_done_pulses", done_cnt - d0, 1);
    chk("hold_b_kept", {16'h0, Add_B}, 32'h0011);
    chk("hold_acc",    {16'h0, Acc},   32'h0111);
    chk("hold_busy",   {31'h0, Busy},  32'h0);
    exp_q.delete();

    // Clear_A + Run + Load_B together: clear and load only, no add.
    d0 = done_cnt;
    drive(1'b1, 1'b1, 1'b1, 16'h0005, 1'b0, none, busy);
    chk("crl_acc",  {16'h0, Acc},   32'h0);
    chk("crl_b",    {16'h0, Add_B}, 32'h0005);
    chk("crl_busy", busy, 0);
    chk("crl_no_done", done_cnt - d0, 0);
    // Load_B + Run together: sum uses the new B.
    drive(1'b1, 1'b0, 1'b1, 16'h0007, 1'b1, '{sum:16'h0007, carry:1'b0, ovf:1'b0}, busy);
    chk("lr_busy", busy, 3);

    // Async reset during SETTLE aborts the add.
    d0 = done_cnt;
    @(negedge Clk);
    Run = 1'b1;
    @(negedge Clk);
    Run = 1'b0;
    #2 Reset_n = 1'b0;
    #1;
    chk("arst_acc",   {16'h0, Acc},   32'h0);
    chk("arst_b",     {16'h0, Add_B}, 32'h0);
    chk("arst_busy",  {31'h0, Busy},  32'h0);
    chk("arst_carry", {31'h0, Carry}, 32'h0);
    chk("arst_done",  {31'h0, Done},  32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (4) @(negedge Clk);
    chk("arst_no_done", done_cnt - d0, 0);
    chk("arst_acc_after", {16'h0, Acc}, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 16'h0010, 1'b1, '{sum:16'h0010, carry:1'b0, ovf:1'b0}, busy);
    chk("post_rst_busy", busy, 3);

    repeat (3) @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
